// File: rtl/volume_ramp_pkg.sv
// Shared definitions for the output-level stage: ramp FSM encodings,
// gain/sample widths and the volume-to-target-gain map.
package volume_ramp_pkg;

    typedef enum logic [1:0] {
        STEADY = 2'b00,
        UP     = 2'b01,
        DOWN   = 2'b10
    } ramp_state_t;

    localparam int GAIN_W_DEF = 10;  // gain g means multiply by g/1024
    localparam int FRAC_W     = 10;  // fixed-point shift matching the 1024 scale
    localparam int SAMPLE_W   = 16;
    localparam int TARGET_W   = 10;

    // Map the 4-bit user volume and mute to a target gain.
    // Full scale (15) is forced to 1023 so the top setting is ~unity.
    function automatic logic [TARGET_W-1:0] target_gain(input logic [3:0] volume,
                                                        input logic       mute);
        logic [TARGET_W-1:0] t;
        if (mute) begin
            t = 10'd0;
        end else begin
            t = {volume, 6'b000000} | ((volume == 4'd15) ? 10'h03F : 10'h000);
        end
        return t;
    endfunction

endpackage

// File: rtl/volume_ramp_gain_ramp.sv
// Gain ramp: target map, ramp direction FSM and gain register.
// Gain steps toward the target by STEP once per input strobe and is clamped
// at the target, so it can neither overshoot nor wrap below zero.
module gain_ramp
    import volume_ramp_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        volume,
    input  logic              mute,
    input  logic              strobe,
    output logic [GAIN_W-1:0] gain,
    output logic              ramp_busy
);
    localparam int                GW1       = GAIN_W + 1;
    localparam logic [GAIN_W:0]   STEP_WIDE = GW1'(STEP);
    localparam logic [GAIN_W-1:0] STEP_G    = GAIN_W'(STEP);

    logic [GAIN_W-1:0] target_s;
    logic [GAIN_W-1:0] gain_r;
    logic [GAIN_W-1:0] gain_next_s;
    logic [GAIN_W:0]   up_sum_s;
    logic [GAIN_W:0]   down_gap_s;
    ramp_state_t       state_r;
    ramp_state_t       state_next_s;
    logic              busy_r;

    // Target gain from the current volume/mute request.
    always_comb begin
        target_s = GAIN_W'(target_gain(volume, mute));
    end

    // Next gain: one clamped step toward the target, only on a strobe.
    always_comb begin
        up_sum_s    = {1'b0, gain_r} + STEP_WIDE;
        down_gap_s  = {1'b0, gain_r} - {1'b0, target_s};
        gain_next_s = gain_r;
        if (strobe) begin
            if (gain_r < target_s) begin
                if (up_sum_s >= {1'b0, target_s}) begin
                    gain_next_s = target_s;
                end else begin
                    gain_next_s = up_sum_s[GAIN_W-1:0];
                end
            end else if (gain_r > target_s) begin
                if (down_gap_s <= STEP_WIDE) begin
                    gain_next_s = target_s;
                end else begin
                    gain_next_s = gain_r - STEP_G;
                end
            end else begin
                gain_next_s = gain_r;
            end
        end else begin
            gain_next_s = gain_r;
        end
    end

    // Ramp direction, re-decided every cycle against the live target.
    always_comb begin
        state_next_s = STEADY;
        case (state_r)
            STEADY: begin
                if (gain_r < target_s) begin
                    state_next_s = UP;
                end else if (gain_r > target_s) begin
                    state_next_s = DOWN;
                end else begin
                    state_next_s = STEADY;
                end
            end
            UP: begin
                if (gain_next_s == target_s) begin
                    state_next_s = STEADY;
                end else if (target_s < gain_next_s) begin
                    state_next_s = DOWN;
                end else begin
                    state_next_s = UP;
                end
            end
            DOWN: begin
                if (gain_next_s == target_s) begin
                    state_next_s = STEADY;
                end else if (target_s > gain_next_s) begin
                    state_next_s = UP;
                end else begin
                    state_next_s = DOWN;
                end
            end
            default: state_next_s = STEADY;
        endcase
    end

    // Gain, state and busy flag registers; reset restarts the ramp from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            gain_r  <= 10'd0;
            state_r <= STEADY;
            busy_r  <= 1'b0;
        end else begin
            gain_r  <= gain_next_s;
            state_r <= state_next_s;
            busy_r  <= (state_next_s != STEADY);
        end
    end

    assign gain      = gain_r;
    assign ramp_busy = busy_r;

endmodule

// File: rtl/volume_ramp.sv
// Output-level stage: scales each echo sample by a click-free ramped gain.
// Two-stage pipeline (multiply, then shift) with a matching strobe delay line.
module volume_ramp
    import volume_ramp_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          volume,
    input  logic                mute,
    input  logic                new_sample_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                new_sample_out,
    output logic                ramp_busy
);
    localparam int PROD_W = GAIN_W + 1 + SAMPLE_W;

    logic [GAIN_W-1:0]        gain_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] prod_r;
    logic                     stage1_valid_r;
    logic                     stage2_valid_r;
    logic [SAMPLE_W-1:0]      result_r;
    logic                     unused_prod_bits_s;

    // The sample uses the gain before this strobe's update; both land on the same edge.
    gain_ramp #(
        .STEP   (STEP),
        .GAIN_W (GAIN_W)
    ) u_gain_ramp (
        .clk       (clk),
        .reset     (reset),
        .volume    (volume),
        .mute      (mute),
        .strobe    (new_sample_in),
        .gain      (gain_s),
        .ramp_busy (ramp_busy)
    );

    // Signed product of the non-negative gain and the sample.
    always_comb begin
        prod_s = PROD_W'($signed({1'b0, gain_s})) * PROD_W'($signed(sample_in));
    end

    // Stage 1: capture strobe and product; product frozen between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_valid_r <= 1'b0;
            prod_r         <= '0;
        end else begin
            stage1_valid_r <= new_sample_in;
            if (new_sample_in) begin
                prod_r <= prod_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // Stage 2: arithmetic shift by the gain scale; output held between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage2_valid_r <= 1'b0;
            result_r       <= 16'd0;
        end else begin
            stage2_valid_r <= stage1_valid_r;
            if (stage1_valid_r) begin
                result_r <= prod_r[FRAC_W +: SAMPLE_W];
            end else begin
                result_r <= result_r;
            end
        end
    end

    // Sign bit and fraction bits of the product never reach the output.
    assign unused_prod_bits_s = ^{prod_r[PROD_W-1:FRAC_W+SAMPLE_W], prod_r[FRAC_W-1:0]};

    assign sample_out     = result_r;
    assign new_sample_out = stage2_valid_r;

endmodule
